// File: rtl/wash_cycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : wash_cycle_controller
//  Description : Washing-machine sequencer. It steps through fill, detergent,
//                timed wash, drain, optional rinse passes and a timed spin.
//                Pause freezes the sequence, an open door latches a fault,
//                and the asynchronous active-low reset abandons any cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module wash_cycle_controller #(
  parameter int WASH_TICKS  = 100,
  parameter int SPIN_TICKS  = 50,
  parameter int RINSE_COUNT = 1,
  parameter int TIMER_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       door_close,
  input  logic       start,
  input  logic       pause,
  input  logic       filled,
  input  logic       detergent_added,
  input  logic       drained,
  output logic       door_lock,
  output logic       motor_on,
  output logic       fill_value_on,
  output logic       drain_value_on,
  output logic       soap_wash,
  output logic       water_wash,
  output logic       done,
  output logic       paused,
  output logic       fault,
  output logic [2:0] state,
  output logic [3:0] rinse_left
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_DETERGENT = 3'd2,
    ST_WASH      = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_SPIN      = 3'd5,
    ST_DONE      = 3'd6,
    ST_FAULT     = 3'd7
  } state_t;

  typedef enum logic {
    PH_SOAP  = 1'b0,
    PH_RINSE = 1'b1
  } phase_t;

  // Timer load values: the timer counts down to zero, so a phase lasting
  // N unpaused clocks is loaded with N-1.
  localparam logic [TIMER_W-1:0] c_wash_last = TIMER_W'(WASH_TICKS - 1);
  localparam logic [TIMER_W-1:0] c_spin_last = TIMER_W'(SPIN_TICKS - 1);
  localparam logic [3:0]         c_rinse_cnt = 4'(RINSE_COUNT);

  state_t             r_state;
  phase_t             r_phase;
  logic               r_paused;
  logic [TIMER_W-1:0] r_timer;
  logic [3:0]         r_rinse_left;

  // States in which the drum is in use: door is locked, pause and the
  // door-open fault apply only here.
  logic w_active;
  logic w_timer_zero;

  assign w_active     = (r_state >= ST_FILL) && (r_state <= ST_SPIN);
  assign w_timer_zero = (r_timer == '0);

  // Sequencer: fault has priority over pause, pause over normal stepping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_phase      <= PH_SOAP;
      r_paused     <= 1'b0;
      r_timer      <= '0;
      r_rinse_left <= 4'd0;
    end else if (w_active && !door_close) begin
      // Door opened with water or motion possible: latch until reset.
      r_state  <= ST_FAULT;
      r_paused <= 1'b0;
    end else if (w_active && pause) begin
      // Frozen: state, timer and sensors are all held/ignored.
      r_paused <= 1'b1;
    end else begin
      r_paused <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && door_close) begin
            r_state      <= ST_FILL;
            r_phase      <= PH_SOAP;
            r_rinse_left <= c_rinse_cnt;
          end
        end

        ST_FILL: begin
          if (filled) begin
            if (r_phase == PH_SOAP) begin
              r_state <= ST_DETERGENT;
            end else begin
              r_state <= ST_WASH;
              r_timer <= c_wash_last;
            end
          end
        end

        ST_DETERGENT: begin
          if (detergent_added) begin
            r_state <= ST_WASH;
            r_timer <= c_wash_last;
          end
        end

        ST_WASH: begin
          if (w_timer_zero) begin
            r_state <= ST_DRAIN;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end

        ST_DRAIN: begin
          if (drained) begin
            if (r_rinse_left != 4'd0) begin
              r_state      <= ST_FILL;
              r_phase      <= PH_RINSE;
              r_rinse_left <= r_rinse_left - 4'd1;
            end else begin
              r_state <= ST_SPIN;
              r_timer <= c_spin_last;
            end
          end
        end

        ST_SPIN: begin
          if (w_timer_zero) begin
            r_state <= ST_DONE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end

        ST_DONE: begin
          // A start level still held from the finished cycle must not
          // launch another one; wait for it to drop first.
          if (!start) begin
            r_state <= ST_IDLE;
          end
        end

        ST_FAULT: begin
          r_state <= ST_FAULT;
        end

        default: begin
          r_state <= ST_FAULT;
        end
      endcase
    end
  end

  // Moore output decode from the registered state, phase and pause flag.
  always_comb begin
    door_lock      = 1'b0;
    motor_on       = 1'b0;
    fill_value_on  = 1'b0;
    drain_value_on = 1'b0;
    soap_wash      = 1'b0;
    water_wash     = 1'b0;
    done           = 1'b0;
    paused         = 1'b0;
    fault          = 1'b0;

    if (w_active) begin
      door_lock = 1'b1;
      paused    = r_paused;
      if (!r_paused) begin
        case (r_state)
          ST_FILL: fill_value_on = 1'b1;
          ST_WASH: begin
            motor_on   = 1'b1;
            soap_wash  = (r_phase == PH_SOAP);
            water_wash = (r_phase == PH_RINSE);
          end
          ST_DRAIN: drain_value_on = 1'b1;
          ST_SPIN: begin
            motor_on       = 1'b1;
            drain_value_on = 1'b1;
          end
          default: begin
            motor_on = 1'b0;
          end
        endcase
      end
    end else if (r_state == ST_DONE) begin
      done = 1'b1;
    end else if (r_state == ST_FAULT) begin
      fault     = 1'b1;
      door_lock = 1'b1;
    end
  end

  assign state      = r_state;
  assign rinse_left = r_rinse_left;

endmodule
`default_nettype wire
